// File: rtl/modem_pkg.sv
// Modem-wide constants shared by tx and rx.
package modem_pkg;

    localparam int MSG_W  = 32;
    localparam int MAX_SF = 32;

endpackage

// File: rtl/spreading_factors_pkg.sv
// Spreading-factor encoding shared by the DCSK tx and rx datapaths.
package spreading_factors_pkg;

    typedef enum logic [1:0] {
        SF4  = 2'd0,
        SF8  = 2'd1,
        SF16 = 2'd2,
        SF32 = 2'd3
    } sf_t;

    function automatic logic [5:0] sf_chips(input sf_t sf);
        logic [5:0] n;
        case (sf)
            SF4:     n = 6'd4;
            SF8:     n = 6'd8;
            SF16:    n = 6'd16;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dcsk_correlator.sv
// Per-bit DCSK correlator: buffers the reference half, counts data/reference
// agreements and emits the bit decision combinationally on the last data chip.
module dcsk_correlator
    import spreading_factors_pkg::*;
#(
    parameter int MAX_SF = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      chip_valid,
    input  logic                      chip,
    input  sf_t                       sf,
    input  logic [$clog2(MAX_SF)-1:0] chip_idx,
    output logic                      bit_valid,
    output logic                      bit_value
);

    localparam int REF_W = MAX_SF / 2;
    localparam int IDX_W = $clog2(REF_W);
    localparam int CNT_W = $clog2(REF_W) + 1;

    logic [REF_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] match_total;
    logic [5:0]       n_chips;
    logic [5:0]       half;
    logic [5:0]       quarter;
    logic [IDX_W-1:0] ref_idx;
    logic             is_ref;
    logic             is_last;
    logic             agree;

    always_comb begin
        n_chips = sf_chips(sf);
        half    = n_chips >> 1;
        quarter = n_chips >> 2;
        is_ref  = 6'(chip_idx) < half;
        is_last = 6'(chip_idx) == (n_chips - 6'd1);
        // After half shifts, reference chip k sits at half-1-k; for data chip
        // k (chip_idx = half+k) that position equals sf-1-chip_idx.
        ref_idx     = IDX_W'(n_chips - 6'd1 - 6'(chip_idx));
        agree       = ~(chip ^ ref_q[ref_idx]);
        match_total = match_q + CNT_W'(agree);

        ref_d     = ref_q;
        match_d   = match_q;
        bit_valid = 1'b0;
        bit_value = 1'b0;
        if (chip_valid) begin
            if (is_ref) begin
                ref_d = {ref_q[REF_W-2:0], chip};
            end else if (is_last) begin
                bit_valid = 1'b1;
                bit_value = 6'(match_total) > quarter;
                match_d   = '0;
            end else begin
                match_d = match_total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q   <= '0;
            match_q <= '0;
        end else begin
            ref_q   <= ref_d;
            match_q <= match_d;
        end
    end

endmodule

// File: rtl/dcsk_demod_top.sv
// DCSK receive demodulator: chip/bit sequencing, per-word SF capture and
// MSB-first word packing with a registered one-cycle word strobe.
module dcsk_demod_top
    import spreading_factors_pkg::*;
#(
    parameter int MSG_W  = modem_pkg::MSG_W,
    parameter int MAX_SF = modem_pkg::MAX_SF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Mod_Data,
    input  logic             Valid,
    input  logic [1:0]       Spread_Factor_Sel,
    output logic [MSG_W-1:0] Out_Data,
    output logic             Valid_Data
);

    localparam int CHIP_W = $clog2(MAX_SF);
    localparam int BIT_W  = $clog2(MSG_W);

    logic [CHIP_W-1:0] chip_cnt_q, chip_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    sf_t               sf_q, sf_d;
    logic [MSG_W-1:0]  word_q, word_d;
    logic [MSG_W-1:0]  out_data_q, out_data_d;
    logic              valid_data_q, valid_data_d;

    sf_t  sf_cur;
    logic word_start;
    logic chip_last;
    logic bit_last;
    logic bit_valid;
    logic bit_value;

    dcsk_correlator #(
        .MAX_SF(MAX_SF)
    ) u_corr (
        .clk       (Clk),
        .rst       (Rst),
        .chip_valid(Valid),
        .chip      (In_Mod_Data),
        .sf        (sf_cur),
        .chip_idx  (chip_cnt_q),
        .bit_valid (bit_valid),
        .bit_value (bit_value)
    );

    always_comb begin
        // The selector is only honoured on the first chip of a word.
        word_start = (chip_cnt_q == '0) && (bit_cnt_q == '0);
        sf_cur     = word_start ? sf_t'(Spread_Factor_Sel) : sf_q;
        chip_last  = 6'(chip_cnt_q) == (sf_chips(sf_cur) - 6'd1);
        bit_last   = bit_cnt_q == BIT_W'(MSG_W - 1);

        chip_cnt_d   = chip_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        sf_d         = sf_q;
        word_d       = word_q;
        out_data_d   = out_data_q;
        valid_data_d = 1'b0;

        if (Valid) begin
            if (word_start) begin
                sf_d = sf_cur;
            end
            if (chip_last) begin
                chip_cnt_d = '0;
                bit_cnt_d  = bit_last ? '0 : bit_cnt_q + 1'b1;
            end else begin
                chip_cnt_d = chip_cnt_q + 1'b1;
            end
        end

        if (bit_valid) begin
            word_d = {word_q[MSG_W-2:0], bit_value};
            if (bit_last) begin
                out_data_d   = {word_q[MSG_W-2:0], bit_value};
                valid_data_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            chip_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            sf_q         <= SF4;
            word_q       <= '0;
            out_data_q   <= '0;
            valid_data_q <= 1'b0;
        end else begin
            chip_cnt_q   <= chip_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sf_q         <= sf_d;
            word_q       <= word_d;
            out_data_q   <= out_data_d;
            valid_data_q <= valid_data_d;
        end
    end

    assign Out_Data   = out_data_q;
    assign Valid_Data = valid_data_q;

endmodule

// File: tb/tb_dcsk_demod_top.sv
// Directed bench for dcsk_demod_top: a small DCSK chip generator drives the
// demodulator and a negedge monitor records every word strobe.
module tb_dcsk_demod_top;
    import spreading_factors_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        In_Mod_Data;
    logic        Valid;
    logic [1:0]  Spread_Factor_Sel;
    logic [31:0] Out_Data;
    logic        Valid_Data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int word_t0 = 0;
    bit mark_start = 1'b0;

    logic [31:0] got_data[$];
    int          got_cyc[$];

    dcsk_demod_top dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .In_Mod_Data      (In_Mod_Data),
        .Valid            (Valid),
        .Spread_Factor_Sel(Spread_Factor_Sel),
        .Out_Data         (Out_Data),
        .Valid_Data       (Valid_Data)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Valid_Data === 1'b1) begin
            got_data.push_back(Out_Data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            Valid = 1'b0;
            In_Mod_Data = 1'($urandom);
        end
    endtask

    task automatic send_chip(input logic c);
        @(negedge Clk);
        if (mark_start) begin
            word_t0 = cyc;
            mark_start = 1'b0;
        end
        Valid = 1'b1;
        In_Mod_Data = c;
    endtask

    task automatic send_bit(input logic b, input int n, input logic [15:0] flip,
                            input int gap_after, input int gap_len);
        logic [15:0] r;
        r = 16'($urandom);
        for (int k = 0; k < n / 2; k++) begin
            send_chip(r[k]);
            if (k == gap_after) idle(gap_len);
        end
        for (int k = 0; k < n / 2; k++) begin
            send_chip((b ? r[k] : ~r[k]) ^ flip[k]);
            if (k + n / 2 == gap_after) idle(gap_len);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input sf_t sf, input int nbits,
                             input logic [15:0] flip_last, input int gap_bit,
                             input int gap_chip, input int gap_len, input int chg_bit);
        int n;
        n = 4 << int'(sf);
        Spread_Factor_Sel = sf;
        mark_start = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) Spread_Factor_Sel = SF4;
            send_bit(w[31-i], n, (i == 31) ? flip_last : 16'h0,
                     (i == gap_bit) ? gap_chip : -1, gap_len);
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int c;
        c = 0;
        while (got_data.size() < n && c < budget) begin
            @(negedge Clk);
            Valid = 1'b0;
            #1;
            c++;
        end
    endtask

    task automatic clear_log();
        got_data.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Valid = 1'b0;
        In_Mod_Data = 1'b0;
        Spread_Factor_Sel = SF4;
        repeat (3) @(negedge Clk);
        total++;
        if (Out_Data !== 32'h0) begin
            bad++;
            $display("FAIL reset_out_data got=%h exp=%h", Out_Data, 32'h0);
        end
        total++;
        if (Valid_Data !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid_data got=%b exp=0", Valid_Data);
        end
        Rst = 1'b0;
        idle(2);
    endtask

    task automatic test_sf4_basic();
        clear_log();
        send_word(32'hA5A5A5A5, SF4, 32, 16'h0, -1, -1, 0, -1);
        wait_pulses(1, 50);
        idle(5);
        total++;
        if (got_data.size() != 1) begin
            bad++;
            $display("FAIL sf4_pulse_count got=%0d exp=1", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== 32'hA5A5A5A5) begin
                bad++;
                $display("FAIL sf4_word got=%h exp=%h", got_data[0], 32'hA5A5A5A5);
            end
            total++;
            if (got_cyc[0] - word_t0 != 128) begin
                bad++;
                $display("FAIL sf4_latency got=%0d exp=128", got_cyc[0] - word_t0);
            end
        end
        total++;
        if (Out_Data !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL sf4_hold got=%h exp=%h", Out_Data, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_word(32'h0F0F3C3C, SF4, 32, 16'h0, -1, -1, 0, -1);
        send_word(32'h8000_0001, SF4, 32, 16'h0, -1, -1, 0, -1);
        wait_pulses(2, 50);
        total++;
        if (got_data.size() != 2) begin
            bad++;
            $display("FAIL b2b_pulse_count got=%0d exp=2", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== 32'h0F0F3C3C || got_data[1] !== 32'h80000001) begin
                bad++;
                $display("FAIL b2b_words got=%h,%h exp=%h,%h", got_data[0], got_data[1],
                         32'h0F0F3C3C, 32'h80000001);
            end
            total++;
            if (got_cyc[1] - got_cyc[0] != 128) begin
                bad++;
                $display("FAIL b2b_spacing got=%0d exp=128", got_cyc[1] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_gap();
        clear_log();
        send_word(32'h12345678, SF16, 32, 16'h0, 13, 5, 5, -1);
        wait_pulses(1, 50);
        total++;
        if (got_data.size() != 1) begin
            bad++;
            $display("FAIL gap_pulse_count got=%0d exp=1", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== 32'h12345678) begin
                bad++;
                $display("FAIL gap_word got=%h exp=%h", got_data[0], 32'h12345678);
            end
            total++;
            if (got_cyc[0] - word_t0 != 517) begin
                bad++;
                $display("FAIL gap_latency got=%0d exp=517", got_cyc[0] - word_t0);
            end
        end
    endtask

    task automatic test_noise();
        logic [31:0] exp_w[3];
        exp_w[0] = 32'hFFFFFFFE;
        exp_w[1] = 32'hFFFFFFFF;
        exp_w[2] = 32'hFFFFFFFE;
        clear_log();
        send_word(32'hFFFFFFFF, SF8, 32, 16'h0003, -1, -1, 0, -1);
        send_word(32'hFFFFFFFF, SF8, 32, 16'h0004, -1, -1, 0, -1);
        send_word(32'hFFFFFFFE, SF8, 32, 16'h0002, -1, -1, 0, -1);
        wait_pulses(3, 50);
        total++;
        if (got_data.size() != 3) begin
            bad++;
            $display("FAIL noise_pulse_count got=%0d exp=3", got_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_data[i] !== exp_w[i]) begin
                    bad++;
                    $display("FAIL noise_word%0d got=%h exp=%h", i, got_data[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_rst_mid_word();
        clear_log();
        send_word(32'hDEADBEEF, SF32, 11, 16'h0, -1, -1, 0, -1);
        @(negedge Clk);
        Valid = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        total++;
        if (Out_Data !== 32'h0) begin
            bad++;
            $display("FAIL rst_clears_out got=%h exp=%h", Out_Data, 32'h0);
        end
        send_word(32'hFFFF0000, SF32, 32, 16'h0, -1, -1, 0, -1);
        wait_pulses(1, 50);
        idle(3);
        total++;
        if (got_data.size() != 1) begin
            bad++;
            $display("FAIL rst_pulse_count got=%0d exp=1", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== 32'hFFFF0000) begin
                bad++;
                $display("FAIL rst_word got=%h exp=%h", got_data[0], 32'hFFFF0000);
            end
        end
    endtask

    task automatic test_sf_change();
        clear_log();
        send_word(32'hC3A50F96, SF8, 32, 16'h0, -1, -1, 0, 5);
        wait_pulses(1, 50);
        total++;
        if (got_data.size() != 1) begin
            bad++;
            $display("FAIL sfchg_first_count got=%0d exp=1", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== 32'hC3A50F96) begin
                bad++;
                $display("FAIL sfchg_first_word got=%h exp=%h", got_data[0], 32'hC3A50F96);
            end
            total++;
            if (got_cyc[0] - word_t0 != 256) begin
                bad++;
                $display("FAIL sfchg_first_latency got=%0d exp=256", got_cyc[0] - word_t0);
            end
        end
        send_word(32'h5A5A1234, SF4, 32, 16'h0, -1, -1, 0, -1);
        wait_pulses(2, 50);
        total++;
        if (got_data.size() != 2) begin
            bad++;
            $display("FAIL sfchg_second_count got=%0d exp=2", got_data.size());
        end else begin
            total++;
            if (got_data[1] !== 32'h5A5A1234) begin
                bad++;
                $display("FAIL sfchg_second_word got=%h exp=%h", got_data[1], 32'h5A5A1234);
            end
            total++;
            if (got_cyc[1] - word_t0 != 128) begin
                bad++;
                $display("FAIL sfchg_second_latency got=%0d exp=128", got_cyc[1] - word_t0);
            end
        end
    endtask

    task automatic test_random_gaps();
        logic [31:0] sent[$];
        logic [31:0] w;
        sf_t         sf;
        clear_log();
        for (int i = 0; i < 24; i++) begin
            w  = $urandom;
            sf = sf_t'($urandom_range(0, 3));
            sent.push_back(w);
            send_word(w, sf, 32, 16'h0, -1, -1, 0, -1);
            idle($urandom_range(1, 9));
        end
        wait_pulses(24, 100);
        total++;
        if (got_data.size() != 24) begin
            bad++;
            $display("FAIL rand_pulse_count got=%0d exp=24", got_data.size());
        end
        for (int i = 0; i < 24 && i < got_data.size(); i++) begin
            total++;
            if (got_data[i] !== sent[i]) begin
                bad++;
                $display("FAIL rand_word%0d got=%h exp=%h", i, got_data[i], sent[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sf4_basic();
        test_back_to_back();
        test_gap();
        test_noise();
        test_rst_mid_word();
        test_sf_change();
        test_random_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
